// File: rtl/fixed_point_multiplier_pkg.sv
// Shared definitions for the fixed-point multiply/divide units: default
// operand format and the control-state encoding used by both sequencers.
package fixed_point_multiplier_pkg;

    // Default operand format: unsigned Q5.5 in a 10-bit word.
    localparam int DEF_WIDTH = 10;
    localparam int DEF_FRAC  = 5;

    // Sequencer states, 2-bit encoded so the divider can share them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fixed_point_multiplier_if.sv
// start/busy/valid handshake and operand/result buses shared by the
// fixed-point arithmetic units. The master drives a request; the slave
// (the arithmetic unit) reports progress and the result.
interface fixed_point_multiplier_if
    import fixed_point_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a_bus;
    logic [WIDTH-1:0] b_bus;
    logic             busy;
    logic             valid;
    logic             ovf;
    logic [WIDTH-1:0] out_bus;

    modport master (
        output start, a_bus, b_bus,
        input  busy, valid, ovf, out_bus
    );

    modport slave (
        input  start, a_bus, b_bus,
        output busy, valid, ovf, out_bus
    );
endinterface

// File: rtl/fixed_point_multiplier_datapath.sv
// Shift-add datapath: operand registers, partial-product accumulator and
// the truncate/saturate stage that produces the Q-format result.
module fixed_point_multiplier_datapath
    import fixed_point_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,     // accepted start: capture operands
    input  logic             step,     // one CALC iteration
    input  logic             last,     // final iteration: write result
    input  logic [CNT_W-1:0] cnt,      // current multiplier bit position
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] out_bus,
    output logic             ovf
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] addend;

    // Next-state logic for operands, accumulator and result registers.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        out_d  = out_q;
        ovf_d  = ovf_q;
        addend = {{WIDTH{1'b0}}, a_q} << cnt;

        if (load) begin
            a_d   = a_in;
            b_d   = b_in;
            p_d   = '0;
            ovf_d = 1'b0;       // result word is held until the new product lands
        end else if (step) begin
            if (b_q[0]) begin
                p_d = p_q + addend;
            end
            b_d = b_q >> 1;

            // The last iteration's add must be included, so the result is
            // taken from the updated accumulator rather than the register.
            if (last) begin
                if (|p_d[2*WIDTH-1:WIDTH+FRAC]) begin
                    out_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    out_d = p_d[FRAC +: WIDTH];
                    ovf_d = 1'b0;
                end
            end
        end
    end

    // Datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops
        // sample their inputs from the same edge, independent of order.
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_bus = out_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned fixed-point multiplier. Consumes one multiplier bit
// per cycle, truncates the product to the operand Q format and saturates
// with an overflow flag when the integer part does not fit.
module fixed_point_multiplier
    import fixed_point_multiplier_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    fixed_point_multiplier_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic             step;
    logic             last;

    // Control FSM: next state, iteration counter and registered status.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                accept = bus.start;
            end
            ST_CALC: begin
                // start is ignored here: no restart, no queuing.
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = bus.start;   // back-to-back start from DONE
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end
    end

    // State, counter and status flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    fixed_point_multiplier_datapath #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .step    (step),
        .last    (last),
        .cnt     (cnt_q),
        .a_in    (bus.a_bus),
        .b_in    (bus.b_bus),
        .out_bus (bus.out_bus),
        .ovf     (bus.ovf)
    );

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Testbench for fixed_point_multiplier: table of Q5.5 products plus
// sequences for ignored start, held start and reset during a multiply.
module tb_fixed_point_multiplier;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] exp_out;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [9:0] out;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;

    fixed_point_multiplier_if #(.WIDTH(10)) bus ();

    fixed_point_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int         tests_run;
    int         tests_failed;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [9:0] prev_out;
    vec_t       vecs[11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            if (sb.size() == 0) begin
                check("valid_without_pending", 32'(bus.valid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_bus", 32'(bus.out_bus), 32'(mon_e.out));
                check("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
                check("busy_low_at_valid", 32'(bus.busy), 0);
            end
        end
    end

    task automatic run_one(input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] exp_out, input logic exp_ovf);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        bus.a_bus = a;
        bus.b_bus = b;
        bus.start = 1'b1;
        sb.push_back('{exp_out, exp_ovf});
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a_bus = 10'($urandom);
        bus.b_bus = 10'($urandom);
        check("busy_after_start", 32'(bus.busy), 1);
        check("ovf_cleared_on_start", 32'(bus.ovf), 0);
        check("out_held_on_start", 32'(bus.out_bus), 32'(prev_out));
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat = i - 1;
                break;
            end
        end
        check("latency", lat, 10);
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.valid), 0);
        check("out_hold", 32'(bus.out_bus), 32'(exp_out));
        check("ovf_hold", 32'(bus.ovf), 32'(exp_ovf));
        prev_out = exp_out;
    endtask

    initial begin
        int vcnt;
        int first_v;
        int last_v;

        vecs[0]  = '{10'd179,  10'd9,    10'd50,   1'b0};  // 5.59375 * 0.28125
        vecs[1]  = '{10'd32,   10'd179,  10'd179,  1'b0};  // 1.0 * x
        vecs[2]  = '{10'd0,    10'd1023, 10'd0,    1'b0};  // zero operand
        vecs[3]  = '{10'd1023, 10'd1023, 10'd1023, 1'b1};  // saturate
        vecs[4]  = '{10'd1,    10'd1,    10'd0,    1'b0};  // truncates to 0
        vecs[5]  = '{10'd1023, 10'd32,   10'd1023, 1'b0};  // largest exact result
        vecs[6]  = '{10'd512,  10'd64,   10'd1023, 1'b1};  // 16.0*2.0 just overflows
        vecs[7]  = '{10'd33,   10'd33,   10'd34,   1'b0};
        vecs[8]  = '{10'd100,  10'd200,  10'd625,  1'b0};
        vecs[9]  = '{10'd31,   10'd31,   10'd30,   1'b0};
        vecs[10] = '{10'd64,   10'd96,   10'd192,  1'b0};  // 2.0 * 3.0

        tests_run    = 0;
        tests_failed = 0;
        prev_out     = '0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.a_bus    = '0;
        bus.b_bus    = '0;

        #12;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_valid", 32'(bus.valid), 0);
        check("reset_ovf", 32'(bus.ovf), 0);
        check("reset_out", 32'(bus.out_bus), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            run_one(vecs[k].a, vecs[k].b, vecs[k].exp_out, vecs[k].exp_ovf);
        end

        // start pulsed in the fourth CALC cycle must be ignored.
        @(posedge clk); #1;
        bus.a_bus = 10'd179;
        bus.b_bus = 10'd9;
        bus.start = 1'b1;
        sb.push_back('{10'd50, 1'b0});
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.a_bus = 10'd1023;
        bus.b_bus = 10'd1023;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        vcnt    = 0;
        first_v = 0;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                vcnt++;
                if (first_v == 0) first_v = i;
            end
        end
        check("ignored_start_valid_cycle", first_v, 7);
        check("ignored_start_pulse_count", vcnt, 1);
        prev_out = 10'd50;

        // start held high: one result every 11 cycles, busy low only in DONE.
        @(posedge clk); #1;
        bus.a_bus = 10'd64;
        bus.b_bus = 10'd96;
        bus.start = 1'b1;
        repeat (3) sb.push_back('{10'd192, 1'b0});
        @(posedge clk);
        vcnt   = 0;
        last_v = 0;
        for (int i = 1; i <= 40 && vcnt < 3; i++) begin
            @(negedge clk);
            check("busy_xor_valid", 32'(bus.busy ^ bus.valid), 1);
            if (bus.valid) begin
                vcnt++;
                if (vcnt == 1) check("held_first_latency", i - 1, 10);
                else           check("held_throughput", i - last_v, 11);
                last_v = i;
                if (vcnt == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("held_result_count", vcnt, 3);
        @(negedge clk);
        check("held_idle_after", 32'(bus.busy), 0);
        prev_out = 10'd192;

        // Reset in the fifth CALC cycle clears everything with no valid pulse.
        @(posedge clk); #1;
        bus.a_bus = 10'd179;
        bus.b_bus = 10'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midcalc_rst_busy", 32'(bus.busy), 0);
        check("midcalc_rst_valid", 32'(bus.valid), 0);
        check("midcalc_rst_ovf", 32'(bus.ovf), 0);
        check("midcalc_rst_out", 32'(bus.out_bus), 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        check("no_valid_after_rst", vcnt, 0);
        prev_out = '0;
        run_one(10'd179, 10'd9, 10'd50, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
